// File: rtl/rt_ray_gen_lanes.sv
// rt_ray_gen_lanes: raster-order primary ray direction generator.
// Emits LANES adjacent pixels per beat; positions are built incrementally
// from latched camera vectors using adds only (no multipliers).
module rt_ray_gen_lanes #(
    parameter int FP_WL      = 32,
    parameter int FP_QW      = 16,
    parameter int COORD_BITS = 12,
    parameter int LANES      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stall,
    input  logic [COORD_BITS-1:0]       image_width,
    input  logic [COORD_BITS-1:0]       image_height,
    input  logic [3*FP_WL-1:0]          pixel_00_loc,
    input  logic [3*FP_WL-1:0]          pixel_delta_u,
    input  logic [3*FP_WL-1:0]          pixel_delta_v,
    input  logic [3*FP_WL-1:0]          camera_center,
    output logic                        valid,
    output logic                        last,
    output logic [COORD_BITS-1:0]       x_out,
    output logic [COORD_BITS-1:0]       y_out,
    output logic [LANES-1:0]            lane_mask,
    output logic [LANES*3*FP_WL-1:0]    ray_dir,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned VW = 3 * FP_WL;
    localparam int unsigned CW = $clog2(LANES) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    // FP_QW only fixes where the binary point is read; arithmetic is plain integer.
    if (FP_QW >= FP_WL) begin : g_qw_exceeds_word
    end

    logic [1:0]            state;
    logic [CW-1:0]         setup_cnt;
    logic [COORD_BITS-1:0] wl, hl, cur_x, cur_y;
    logic [VW-1:0]         du, dv, cam;
    logic [VW-1:0]         acc;        // becomes LANES*du (the stride) at end of SETUP
    logic [VW-1:0]         row_base;   // position of (0, cur_y)
    logic [VW-1:0]         grp_base;   // position of (cur_x, cur_y)
    logic [VW-1:0]         offs [LANES];

    logic [COORD_BITS:0]   nx;
    logic                  row_end;
    logic                  last_c;
    logic [LANES-1:0]      mask_c;
    logic [LANES*VW-1:0]   ray_c;

    function automatic logic [VW-1:0] vadd(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < 3; c++)
            r[c*FP_WL +: FP_WL] = a[c*FP_WL +: FP_WL] + b[c*FP_WL +: FP_WL];
        return r;
    endfunction

    function automatic logic [VW-1:0] vsub(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < 3; c++)
            r[c*FP_WL +: FP_WL] = a[c*FP_WL +: FP_WL] - b[c*FP_WL +: FP_WL];
        return r;
    endfunction

    assign busy = (state != IDLE);

    // Next-beat contents derived from the current traversal position
    always_comb begin
        nx      = {1'b0, cur_x} + (COORD_BITS+1)'(LANES);
        row_end = (nx >= {1'b0, wl});
        last_c  = row_end && (cur_y == hl - COORD_BITS'(1));
        mask_c  = '0;
        ray_c   = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            mask_c[k]            = (({1'b0, cur_x} + (COORD_BITS+1)'(k)) < {1'b0, wl});
            ray_c[k*VW +: VW]    = vsub(vadd(grp_base, offs[k]), cam);
        end
    end

    // Control FSM, lane-offset setup, traversal and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            setup_cnt <= '0;
            valid     <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            lane_mask <= '0;
            ray_dir   <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        wl        <= image_width;
                        hl        <= image_height;
                        du        <= pixel_delta_u;
                        dv        <= pixel_delta_v;
                        cam       <= camera_center;
                        row_base  <= pixel_00_loc;
                        grp_base  <= pixel_00_loc;
                        acc       <= '0;
                        setup_cnt <= '0;
                        cur_x     <= '0;
                        cur_y     <= '0;
                        if (image_width == '0 || image_height == '0)
                            done <= 1'b1;
                        else
                            state <= SETUP;
                    end
                end
                SETUP: begin
                    for (int unsigned k = 0; k < LANES; k++)
                        if (setup_cnt == CW'(k))
                            offs[k] <= acc;
                    acc       <= vadd(acc, du);
                    setup_cnt <= setup_cnt + CW'(1);
                    if (setup_cnt == CW'(LANES - 1))
                        state <= RUN;
                end
                RUN: begin
                    // A final beat in the register blocks further loads until accepted.
                    if (valid && last) begin
                        if (!stall) begin
                            valid <= 1'b0;
                            last  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (!valid || !stall) begin
                        valid     <= 1'b1;
                        last      <= last_c;
                        x_out     <= cur_x;
                        y_out     <= cur_y;
                        lane_mask <= mask_c;
                        ray_dir   <= ray_c;
                        if (row_end) begin
                            cur_x    <= '0;
                            cur_y    <= cur_y + COORD_BITS'(1);
                            row_base <= vadd(row_base, dv);
                            grp_base <= vadd(row_base, dv);
                        end else begin
                            cur_x    <= nx[COORD_BITS-1:0];
                            grp_base <= vadd(grp_base, acc);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rt_ray_gen_lanes.sv
// Directed bench for rt_ray_gen_lanes: a LANES=2 instance for the main
// frames and a LANES=1 instance for the single-lane corner case.
module tb_rt_ray_gen_lanes;

    localparam int WL = 32;
    localparam int CB = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // LANES=2 instance
    logic            start_a = 1'b0, stall_a = 1'b0;
    logic [CB-1:0]   w_a = '0, h_a = '0;
    logic [3*WL-1:0] p00_a = '0, du_a = '0, dv_a = '0, cam_a = '0;
    logic            valid_a, last_a, busy_a, done_a;
    logic [CB-1:0]   x_a, y_a;
    logic [1:0]      mask_a;
    logic [2*3*WL-1:0] ray_a;

    // LANES=1 instance
    logic            start_b = 1'b0;
    logic [CB-1:0]   w_b = '0, h_b = '0;
    logic [3*WL-1:0] cam_b = '0;
    logic            valid_b, last_b, busy_b, done_b;
    logic [CB-1:0]   x_b, y_b;
    logic [0:0]      mask_b;
    logic [3*WL-1:0] ray_b;

    rt_ray_gen_lanes #(.FP_WL(WL), .FP_QW(16), .COORD_BITS(CB), .LANES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stall(stall_a),
        .image_width(w_a), .image_height(h_a),
        .pixel_00_loc(p00_a), .pixel_delta_u(du_a), .pixel_delta_v(dv_a), .camera_center(cam_a),
        .valid(valid_a), .last(last_a), .x_out(x_a), .y_out(y_a),
        .lane_mask(mask_a), .ray_dir(ray_a), .busy(busy_a), .done(done_a)
    );

    rt_ray_gen_lanes #(.FP_WL(WL), .FP_QW(16), .COORD_BITS(CB), .LANES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stall(1'b0),
        .image_width(w_b), .image_height(h_b),
        .pixel_00_loc({3*WL{1'b0}}), .pixel_delta_u({32'd0, 32'd0, 32'h0001_0000}),
        .pixel_delta_v({32'd0, 32'h0001_0000, 32'd0}), .camera_center(cam_b),
        .valid(valid_b), .last(last_b), .x_out(x_b), .y_out(y_b),
        .lane_mask(mask_b), .ray_dir(ray_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_a(output int n);
        n = 0;
        while (!valid_a && n < 20) begin
            step();
            n++;
        end
    endtask

    logic [191:0] held;
    int n, beats, lasts;
    logic [CB-1:0] lx, ly;

    initial begin
        // reset state
        step(); step();
        chk("rst_valid", 192'(valid_a), 192'(0));
        chk("rst_busy",  192'(busy_a),  192'(0));
        chk("rst_done",  192'(done_a),  192'(0));
        chk("rst_ray",   ray_a,         192'(0));
        rst = 1'b0;

        // basic 3x2 frame
        w_a = 12'd3; h_a = 12'd2;
        du_a = {32'd0, 32'd0, 32'h0001_0000};
        dv_a = {32'd0, 32'h0001_0000, 32'd0};
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("busy_setup", 192'(busy_a), 192'(1));
        wait_valid_a(n);
        chk("first_latency", 192'(n), 192'(3));
        chk("b1_xy",   192'({x_a, y_a}), 192'({12'd0, 12'd0}));
        chk("b1_mask", 192'(mask_a), 192'(2'b11));
        chk("b1_l1x",  192'(ray_a[127:96]), 192'(32'h0001_0000));
        chk("b1_last", 192'(last_a), 192'(0));
        step();
        chk("b2_xy",   192'({x_a, y_a}), 192'({12'd2, 12'd0}));
        chk("b2_mask", 192'(mask_a), 192'(2'b01));
        chk("b2_l0x",  192'(ray_a[31:0]), 192'(32'h0002_0000));
        chk("b2_l1x_extrap", 192'(ray_a[127:96]), 192'(32'h0003_0000));
        step();
        chk("b3_xy",   192'({x_a, y_a}), 192'({12'd0, 12'd1}));
        chk("b3_mask", 192'(mask_a), 192'(2'b11));
        chk("b3_l0y",  192'(ray_a[63:32]), 192'(32'h0001_0000));
        step();
        chk("b4_xy",   192'({x_a, y_a}), 192'({12'd2, 12'd1}));
        chk("b4_mask", 192'(mask_a), 192'(2'b01));
        chk("b4_last", 192'(last_a), 192'(1));
        step();
        chk("end_valid", 192'(valid_a), 192'(0));
        chk("end_last",  192'(last_a),  192'(0));
        chk("end_done",  192'(done_a),  192'(1));
        chk("end_busy",  192'(busy_a),  192'(0));
        step();
        chk("done_pulse_one", 192'(done_a), 192'(0));

        // same frame, stall on beat 2, stray start and input change mid-run
        start_a = 1'b1; step(); start_a = 1'b0;
        wait_valid_a(n);
        chk("s_latency", 192'(n), 192'(3));
        step();
        chk("s_b2_xy", 192'({x_a, y_a}), 192'({12'd2, 12'd0}));
        held = ray_a;
        stall_a = 1'b1;
        start_a = 1'b1;
        w_a = 12'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            start_a = 1'b0;
            chk("s_hold_xy",   192'({valid_a, x_a, y_a, mask_a}), 192'({1'b1, 12'd2, 12'd0, 2'b01}));
            chk("s_hold_ray",  ray_a, held);
        end
        stall_a = 1'b0;
        step();
        chk("s_b3_xy", 192'({x_a, y_a, mask_a}), 192'({12'd0, 12'd1, 2'b11}));
        step();
        chk("s_b4", 192'({x_a, y_a, mask_a, last_a}), 192'({12'd2, 12'd1, 2'b01, 1'b1}));
        step();
        chk("s_done", 192'({done_a, valid_a}), 192'({1'b1, 1'b0}));
        w_a = 12'd3;

        // zero-width frame
        w_a = 12'd0; h_a = 12'd5;
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("z_done", 192'({done_a, valid_a, busy_a}), 192'({1'b1, 1'b0, 1'b0}));
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (valid_a || busy_a || done_a) n++;
        end
        chk("z_quiet", 192'(n), 192'(0));

        // single-lane, single-pixel frame with offset camera
        w_b = 12'd1; h_b = 12'd1; cam_b = {32'd0, 32'd0, 32'h0001_0000};
        start_b = 1'b1; step(); start_b = 1'b0;
        n = 0;
        while (!valid_b && n < 20) begin
            step();
            n++;
        end
        chk("l1_latency", 192'(n), 192'(2));
        chk("l1_beat", 192'({mask_b, last_b, x_b, y_b}), 192'({1'b1, 1'b1, 12'd0, 12'd0}));
        chk("l1_rayx", 192'(ray_b[31:0]), 192'(32'hFFFF_0000));
        step();
        chk("l1_done", 192'({done_b, valid_b}), 192'({1'b1, 1'b0}));

        // 4x4 frame aborted by reset at beat 2, then a full 4x4 frame
        w_a = 12'd4; h_a = 12'd4;
        start_a = 1'b1; step(); start_a = 1'b0;
        wait_valid_a(n);
        step();
        chk("a_b2_xy", 192'({x_a, y_a}), 192'({12'd2, 12'd0}));
        rst = 1'b1; step(); rst = 1'b0;
        chk("a_rst_ctl", 192'({valid_a, last_a, done_a, busy_a}), 192'(0));
        chk("a_rst_dat", 192'({x_a, y_a, mask_a}), 192'(0));
        chk("a_rst_ray", ray_a, 192'(0));
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (valid_a || done_a || busy_a) n++;
        end
        chk("a_no_resume", 192'(n), 192'(0));
        start_a = 1'b1; step(); start_a = 1'b0;
        beats = 0; lasts = 0; n = 0; lx = '0; ly = '0;
        while (!done_a && n < 100) begin
            step();
            n++;
            if (valid_a) begin
                beats++;
                if (last_a) begin
                    lasts++;
                    lx = x_a; ly = y_a;
                end
            end
        end
        chk("f_done_seen", 192'(done_a), 192'(1));
        chk("f_beats", 192'(beats), 192'(8));
        chk("f_lasts", 192'(lasts), 192'(1));
        chk("f_last_xy", 192'({lx, ly}), 192'({12'd2, 12'd3}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rt_ray_gen_lanes.md
RT_RAY_GEN_LANES -- requirements
Module: rt_ray_gen_lanes

Interface
REQ-001 Parameter FP_WL, default 32: fixed-point word length, signed two's complement.
REQ-002 Parameter FP_QW, default 16: fractional bits; fixed-point scaling only, no effect on arithmetic.
REQ-003 Parameter COORD_BITS, default 12: pixel coordinate and image dimension width.
REQ-004 Parameter LANES, default 2, legal range 1..8: pixels emitted per output beat.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  frame start request; honoured only in IDLE.
REQ-008 stall  in  1  downstream back-pressure; high = hold the current output beat.
REQ-009 image_width, image_height  in  COORD_BITS each  frame dimensions in pixels.
REQ-010 pixel_00_loc, pixel_delta_u, pixel_delta_v, camera_center  in  3*FP_WL each  xyz vectors; component 0 in bits [FP_WL-1:0].
REQ-011 valid  out  1  output beat present.
REQ-012 last  out  1  beat is the final beat of the frame.
REQ-013 x_out, y_out  out  COORD_BITS each  coordinates of lane 0 of the beat.
REQ-014 lane_mask  out  LANES  bit k high = lane k holds an in-image pixel.
REQ-015 ray_dir  out  LANES*3*FP_WL  lane k, component c at offset (3k+c)*FP_WL.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at frame end.

Function
REQ-018 States SHALL be IDLE, SETUP, RUN.
REQ-019 IDLE with start=1 SHALL latch all dimension and vector inputs and enter SETUP; later input changes SHALL be ignored until the next IDLE.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 SETUP SHALL last exactly LANES cycles, accumulating lane offsets k*delta_u (k=0..LANES-1) and the stride LANES*delta_u by repeated addition, one add per cycle, no multipliers.
REQ-022 Frame with image_width=0 or image_height=0: SETUP SHALL be skipped, done SHALL pulse the cycle after start is sampled, state SHALL return to IDLE, and no beat SHALL be emitted.
REQ-023 Position of pixel (x,y) = pixel_00_loc + x*delta_u + y*delta_v. SHALL be produced incrementally: row base += delta_v per row, group base += stride per beat.
REQ-024 ray_dir lane k = position(x+k, y) - camera_center, per component.
REQ-025 All adds and subtracts SHALL be FP_WL-bit and wrap modulo 2^FP_WL, with no saturation.
REQ-026 Traversal SHALL be raster order: x = 0, LANES, 2*LANES, ... < image_width; then y+1, x=0.
REQ-027 Beats per frame SHALL equal image_height*ceil(image_width/LANES).
REQ-028 lane_mask bit k SHALL equal (x_out+k < image_width).
REQ-029 ray_dir of a masked lane SHALL be the extrapolated value per REQ-024.
REQ-030 The output register SHALL load in RUN whenever valid=0 or stall=0. The first valid SHALL rise LANES+1 cycles after the cycle in which start was sampled.
REQ-031 While valid=1 and stall=1, all outputs SHALL hold unchanged and traversal SHALL not advance.
REQ-032 Beats SHALL be back-to-back, one per cycle, while stall=0.
REQ-033 last SHALL be high only with the beat whose y_out=image_height-1 and whose group contains x=image_width-1.
REQ-034 The cycle after the last beat is accepted (valid=1, stall=0), valid and last SHALL clear, done SHALL pulse for one cycle, and state SHALL return to IDLE.
REQ-035 start in the done cycle SHALL be honoured.

Reset
REQ-036 rst=1 SHALL force IDLE and drive valid, last, done and busy to 0, and x_out, y_out, lane_mask and ray_dir to 0, at the next edge, in any state including mid-frame.
REQ-037 An aborted frame SHALL not resume and SHALL not pulse done.

Verification
REQ-038 Vectors: LANES=2, FP_QW=16, width=3, height=2, p00=0, du=(0x00010000,0,0), dv=(0,0x00010000,0), camera=0. Required beats:
- (x0,y0), mask 11, lane1 x-component 0x00010000
- (x2,y0), mask 01
- (x0,y1), mask 11, lane0 y-component 0x00010000
- (x2,y1), mask 01, last=1
- done pulses the following cycle.
REQ-039 Same frame with stall held high for 3 cycles on beat 2: beat 2 holds for 4 cycles with outputs unchanged; beat order and count unchanged.
REQ-040 width=0, height=5, start: done pulses the next cycle; valid never rises; busy low afterwards.
REQ-041 LANES=1, width=1, height=1, camera=(0x00010000,0,0), p00=0: single beat, mask 1, last=1, ray_dir x-component 0xFFFF0000.
REQ-042 rst asserted at beat 2 of a 4x4 frame: outputs zero at the next edge; new start runs a complete 4x4 frame with correct beat count.
REQ-043 start pulsed during RUN: no effect on the current frame.
